ber_align: RTL and testbench
============================

// Module: ber_align
// PURPOSE
//  Bit-error-rate checker with automatic latency alignment, successor to the fixed-alignment ber counter.
//  Compares the received stream i_rx against the local PRBS reference i_ref, searching delays 0..MAX_DELAY-1 for the best alignment.
//  Locks to that delay, then accumulates error and bit counts. Drops lock and re-searches when alignment is lost.
//  Sits between prbs9 (reference) and the channel/receiver output in BER test benches and link bring-up.
// PARAMETERS
//  MAX_DELAY   16   candidate delays 0..MAX_DELAY-1; reference history depth, in valid samples (>=2)
//  WINDOW      128  valid samples per evaluation window (search and lock monitor)
//  LOCK_THR    0    max errors in the best window for a sweep to lock
//  UNLOCK_THR  16   errors in one LOCKED window above which lock is dropped
//  CNT_W       64   width of o_errors / o_bits
// PORTS
//  clock          in   1               system clock, all logic on posedge
//  i_reset        in   1               synchronous reset, active-high
//  i_valid        in   1               i_rx/i_ref sample valid this cycle
//  i_rx           in   1               received bit
//  i_ref          in   1               reference bit (unaligned)
//  i_clear        in   1               zero o_errors/o_bits, no state change
//  o_errors       out  CNT_W           accumulated errors while LOCKED
//  o_bits         out  CNT_W           accumulated compared bits while LOCKED
//  o_locked       out  1               1 in LOCKED
//  o_delay        out  $clog2(MAX_DELAY)  locked delay (valid when o_locked)
//  o_state        out  2               0=FILL 1=SEARCH 2=LOCKED
//  o_sweep_fails  out  16              sweeps ending above LOCK_THR, saturating
//  o_unlocks      out  16              LOCKED->SEARCH transitions, saturating
// BEHAVIOUR
//  - Reset: all outputs 0, history cleared, state FILL. Reset mid-operation: same result in one cycle, overrides all.
//  - History: ref_d[0] = i_ref (current); ref_d[k] = i_ref of the k-th previous valid sample. Shifts only when i_valid=1.
//  - mismatch(d) = i_rx ^ ref_d[d], evaluated only on valid cycles. All outputs registered; 1-cycle latency.
//  - Idle cycles (i_valid=0) change no counters or state.
//  - FILL: count MAX_DELAY valid samples. On the MAX_DELAY-th -> SEARCH with cand=0, window cleared, best=all-ones.
//  - SEARCH: each valid sample: win_bits+1, win_err+=mismatch(cand).
//    On the sample making win_bits==WINDOW (that sample's error included):
//      if win_err < best -> best=win_err, best_d=cand (strict <, ties keep the lower delay); clear window.
//      cand<MAX_DELAY-1 -> cand+1.
//      cand==MAX_DELAY-1 and best<=LOCK_THR -> LOCKED, o_delay=best_d, o_locked=1.
//      cand==MAX_DELAY-1 otherwise -> o_sweep_fails+1, cand=0, best=all-ones, stay in SEARCH.
//  - LOCKED: each valid sample: o_bits+1, o_errors+=mismatch(o_delay); same window monitor runs.
//    At a window end with win_err > UNLOCK_THR -> SEARCH (cand=0, best reset), o_locked=0, o_unlocks+1.
//    o_errors/o_bits/o_delay hold their values outside LOCKED.
//  - o_errors, o_bits, o_sweep_fails, o_unlocks each saturate at all-ones independently (no wrap).
//  - i_clear: next cycle o_errors=o_bits=0. Coincident valid LOCKED sample is discarded (clear wins). State/window unaffected.
//  - Full sweep length: MAX_DELAY*WINDOW valid samples; first lock no earlier than MAX_DELAY+MAX_DELAY*WINDOW valid samples.
// TESTING (defaults; prbs9 SEED='h1AA; i_ref=prbs9; i_rx = i_ref delayed 11 clocks; i_valid=1 unless stated)
//  1 Reset release -> o_locked=1, o_delay=11 on the cycle after valid sample 2064; after 10000 further samples o_bits=10000, o_errors=0.
//  2 Locked; flip i_rx every 100th bit -> after 10000 bits o_errors=100; o_locked stays 1, o_unlocks=0.
//  3 i_rx delayed 20 (out of range) -> never locks; o_sweep_fails increments every 2048 valid samples.
//  4 Locked at 11; switch delay to 5 -> unlock at next window end (o_unlocks=1, counts held); relock o_delay=5 within 2048+128 samples.
//  5 i_valid alternating 1/0 -> same o_delay=11 (history shifts per valid sample); o_bits counts only valid cycles.
//  6 i_clear with valid sample in LOCKED -> o_errors=o_bits=0 next cycle; i_reset mid-LOCKED -> all outputs 0, o_state=0.

Source files
------------

// File: rtl/ber_align.sv
// ber_align: BER checker that sweeps candidate reference delays, locks to the
// best one, then counts errors and compared bits. Drops lock and re-sweeps when
// a monitoring window shows too many errors.
module ber_align #(
  parameter int MAX_DELAY  = 16,
  parameter int WINDOW     = 128,
  parameter int LOCK_THR   = 0,
  parameter int UNLOCK_THR = 16,
  parameter int CNT_W      = 64,
  localparam int DW        = (MAX_DELAY > 1) ? $clog2(MAX_DELAY) : 1
) (
  input  logic             clock,
  input  logic             i_reset,
  input  logic             i_valid,
  input  logic             i_rx,
  input  logic             i_ref,
  input  logic             i_clear,
  output logic [CNT_W-1:0] o_errors,
  output logic [CNT_W-1:0] o_bits,
  output logic             o_locked,
  output logic [DW-1:0]    o_delay,
  output logic [1:0]       o_state,
  output logic [15:0]      o_sweep_fails,
  output logic [15:0]      o_unlocks
);

  // Fill counter must reach MAX_DELAY; window counters get one spare bit so the
  // all-ones "no best yet" value is strictly above any real window error count.
  localparam int FW = $clog2(MAX_DELAY + 1);
  localparam int WW = $clog2(WINDOW + 1) + 1;

  typedef enum logic [1:0] {
    FILL   = 2'd0,
    SEARCH = 2'd1,
    LOCKED = 2'd2
  } state_t;

  state_t               state_reg;
  logic [FW-1:0]        fill_cnt_reg;
  logic [DW-1:0]        cand_reg;
  logic [WW-1:0]        win_bits_reg;
  logic [WW-1:0]        win_err_reg;
  logic [WW-1:0]        best_reg;
  logic [DW-1:0]        best_d_reg;

  // ref_vec[k] is the reference bit k valid samples ago; ref_vec[0] is current.
  logic [MAX_DELAY-1:0] ref_vec;
  logic [MAX_DELAY-1:1] hist_reg;

  assign ref_vec[0] = i_ref;

  genvar gi;
  generate
    for (gi = 1; gi < MAX_DELAY; gi++) begin : g_hist
      // One history stage; advances only on valid samples.
      always_ff @(posedge clock) begin
        if (i_reset) begin
          hist_reg[gi] <= 1'b0;
        end else if (i_valid) begin
          hist_reg[gi] <= ref_vec[gi-1];
        end
      end
      assign ref_vec[gi] = hist_reg[gi];
    end
  endgenerate

  // Window statistics for this sample, using the candidate during search and
  // the locked delay while locked.
  logic [DW-1:0] sel_d;
  logic          mism;
  logic          mism_lock;
  logic [WW-1:0] win_bits_next;
  logic [WW-1:0] win_err_next;
  logic          win_end;
  logic [WW-1:0] best_next;
  logic [DW-1:0] best_d_next;

  // Combinational window update and best-candidate selection.
  always_comb begin
    sel_d         = (state_reg == LOCKED) ? o_delay : cand_reg;
    mism          = i_rx ^ ref_vec[sel_d];
    mism_lock     = i_rx ^ ref_vec[o_delay];
    win_bits_next = win_bits_reg + WW'(1);
    win_err_next  = win_err_reg + WW'(mism);
    win_end       = (win_bits_next == WW'(WINDOW));
    best_next     = best_reg;
    best_d_next   = best_d_reg;
    if (win_err_next < best_reg) begin
      best_next   = win_err_next;
      best_d_next = cand_reg;
    end
  end

  assign o_state = state_reg;

  // Main state machine, window monitor and output counters.
  always_ff @(posedge clock) begin
    if (i_reset) begin
      state_reg     <= FILL;
      fill_cnt_reg  <= '0;
      cand_reg      <= '0;
      win_bits_reg  <= '0;
      win_err_reg   <= '0;
      best_reg      <= '1;
      best_d_reg    <= '0;
      o_errors      <= '0;
      o_bits        <= '0;
      o_locked      <= 1'b0;
      o_delay       <= '0;
      o_sweep_fails <= '0;
      o_unlocks     <= '0;
    end else begin
      if (i_valid) begin
        case (state_reg)
          FILL: begin
            if (fill_cnt_reg == FW'(MAX_DELAY - 1)) begin
              state_reg    <= SEARCH;
              cand_reg     <= '0;
              win_bits_reg <= '0;
              win_err_reg  <= '0;
              best_reg     <= '1;
            end else begin
              fill_cnt_reg <= fill_cnt_reg + FW'(1);
            end
          end

          SEARCH: begin
            if (win_end) begin
              win_bits_reg <= '0;
              win_err_reg  <= '0;
              if (cand_reg != DW'(MAX_DELAY - 1)) begin
                cand_reg   <= cand_reg + DW'(1);
                best_reg   <= best_next;
                best_d_reg <= best_d_next;
              end else if (best_next <= WW'(LOCK_THR)) begin
                state_reg  <= LOCKED;
                o_delay    <= best_d_next;
                o_locked   <= 1'b1;
                best_reg   <= best_next;
                best_d_reg <= best_d_next;
              end else begin
                if (o_sweep_fails != 16'hFFFF) begin
                  o_sweep_fails <= o_sweep_fails + 16'd1;
                end
                cand_reg <= '0;
                best_reg <= '1;
              end
            end else begin
              win_bits_reg <= win_bits_next;
              win_err_reg  <= win_err_next;
            end
          end

          LOCKED: begin
            if (o_bits != '1) begin
              o_bits <= o_bits + CNT_W'(1);
            end
            if (mism_lock && (o_errors != '1)) begin
              o_errors <= o_errors + CNT_W'(1);
            end
            if (win_end) begin
              win_bits_reg <= '0;
              win_err_reg  <= '0;
              if (win_err_next > WW'(UNLOCK_THR)) begin
                state_reg <= SEARCH;
                cand_reg  <= '0;
                best_reg  <= '1;
                o_locked  <= 1'b0;
                if (o_unlocks != 16'hFFFF) begin
                  o_unlocks <= o_unlocks + 16'd1;
                end
              end
            end else begin
              win_bits_reg <= win_bits_next;
              win_err_reg  <= win_err_next;
            end
          end

          default: begin
            state_reg <= FILL;
          end
        endcase
      end

      // Clear has the last word so a coincident locked sample is discarded.
      if (i_clear) begin
        o_errors <= '0;
        o_bits   <= '0;
      end
    end
  end

endmodule

// File: tb/tb_ber_align.sv
// tb_ber_align: table-driven directed test of ber_align with a PRBS9 reference
// and a delayed copy as the received stream, plus hand-written corner sequences.
module tb_ber_align;

  logic        clock;
  logic        i_reset;
  logic        i_valid;
  logic        i_rx;
  logic        i_ref;
  logic        i_clear;
  logic [63:0] o_errors;
  logic [63:0] o_bits;
  logic        o_locked;
  logic [3:0]  o_delay;
  logic [1:0]  o_state;
  logic [15:0] o_sweep_fails;
  logic [15:0] o_unlocks;

  ber_align dut (
    .clock         (clock),
    .i_reset       (i_reset),
    .i_valid       (i_valid),
    .i_rx          (i_rx),
    .i_ref         (i_ref),
    .i_clear       (i_clear),
    .o_errors      (o_errors),
    .o_bits        (o_bits),
    .o_locked      (o_locked),
    .o_delay       (o_delay),
    .o_state       (o_state),
    .o_sweep_fails (o_sweep_fails),
    .o_unlocks     (o_unlocks)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int n_cmp = 0;
  int n_bad = 0;

  logic [8:0]  lfsr = 9'h1AA;
  logic [31:0] bh   = '0;

  typedef struct {
    int rst;      // pulse reset before this record
    int clr;      // idle cycle with i_clear before this record
    int alt;      // each valid sample followed by an idle cycle
    int dly;      // channel delay in valid samples
    int flip;     // invert every flip-th received bit (0 = never)
    int n;        // valid samples in this record
    int e_state;
    int e_delay;
    int e_bits;
    int chk_err;
    int e_err;
    int e_fails;
    int e_unl;
  } vec_t;

  localparam int NV = 17;
  vec_t tbl [NV];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic do_reset();
    i_reset = 1'b1;
    i_valid = 1'b0;
    i_clear = 1'b0;
    @(posedge clock); #1;
    i_reset = 1'b0;
    bh = '0;
  endtask

  task automatic do_sample(input int dly, input logic flp, input logic clr);
    logic fb;
    fb      = lfsr[8] ^ lfsr[4];
    lfsr    = {lfsr[7:0], fb};
    bh      = {bh[30:0], fb};
    i_ref   = fb;
    i_rx    = bh[dly] ^ flp;
    i_valid = 1'b1;
    i_clear = clr;
    @(posedge clock); #1;
    i_valid = 1'b0;
    i_clear = 1'b0;
  endtask

  task automatic do_idle(input logic clr);
    i_valid = 1'b0;
    i_clear = clr;
    @(posedge clock); #1;
    i_clear = 1'b0;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, ".state"},  64'(o_state), 64'd0);
    chk({tag, ".locked"}, 64'(o_locked), 64'd0);
    chk({tag, ".delay"},  64'(o_delay), 64'd0);
    chk({tag, ".bits"},   o_bits, 64'd0);
    chk({tag, ".errors"}, o_errors, 64'd0);
    chk({tag, ".fails"},  64'(o_sweep_fails), 64'd0);
    chk({tag, ".unlocks"},64'(o_unlocks), 64'd0);
  endtask

  initial begin
    //        rst clr alt dly flip n      st dly bits   ce err fl un
    tbl[0]  = '{1, 0, 0, 11, 0,   15,    0, 0,  0,     1, 0,  0, 0};
    tbl[1]  = '{0, 0, 0, 11, 0,   1,     1, 0,  0,     1, 0,  0, 0};
    tbl[2]  = '{0, 0, 0, 11, 0,   2047,  1, 0,  0,     1, 0,  0, 0};
    tbl[3]  = '{0, 0, 0, 11, 0,   1,     2, 11, 0,     1, 0,  0, 0};
    tbl[4]  = '{0, 0, 0, 11, 0,   10000, 2, 11, 10000, 1, 0,  0, 0};
    tbl[5]  = '{0, 1, 0, 11, 100, 10000, 2, 11, 10000, 1, 100,0, 0};
    tbl[6]  = '{0, 0, 0, 5,  0,   95,    2, 11, 10095, 0, 0,  0, 0};
    tbl[7]  = '{0, 0, 0, 5,  0,   1,     1, 11, 10096, 0, 0,  0, 1};
    tbl[8]  = '{0, 0, 0, 5,  0,   2047,  1, 11, 10096, 0, 0,  0, 1};
    tbl[9]  = '{0, 0, 0, 5,  0,   1,     2, 5,  10096, 0, 0,  0, 1};
    tbl[10] = '{0, 1, 0, 5,  0,   500,   2, 5,  500,   1, 0,  0, 1};
    tbl[11] = '{1, 0, 0, 20, 0,   2063,  1, 0,  0,     1, 0,  0, 0};
    tbl[12] = '{0, 0, 0, 20, 0,   1,     1, 0,  0,     1, 0,  1, 0};
    tbl[13] = '{0, 0, 0, 20, 0,   2048,  1, 0,  0,     1, 0,  2, 0};
    tbl[14] = '{1, 0, 1, 11, 0,   2063,  1, 0,  0,     1, 0,  0, 0};
    tbl[15] = '{0, 0, 1, 11, 0,   1,     2, 11, 0,     1, 0,  0, 0};
    tbl[16] = '{0, 0, 1, 11, 0,   1000,  2, 11, 1000,  1, 0,  0, 0};

    i_reset = 1'b1;
    i_valid = 1'b0;
    i_rx    = 1'b0;
    i_ref   = 1'b0;
    i_clear = 1'b0;
    repeat (3) @(posedge clock);
    #1;
    i_reset = 1'b0;
    chk_all_zero("reset");
    $display("reset: state=%0d locked=%0d bits=%0d", o_state, o_locked, o_bits);

    for (int r = 0; r < NV; r++) begin
      if (tbl[r].rst != 0) do_reset();
      if (tbl[r].clr != 0) do_idle(1'b1);
      for (int k = 0; k < tbl[r].n; k++) begin
        logic flp;
        flp = (tbl[r].flip != 0) && ((k % tbl[r].flip) == tbl[r].flip - 1);
        do_sample(tbl[r].dly, flp, 1'b0);
        if (tbl[r].alt != 0) do_idle(1'b0);
      end
      chk($sformatf("rec%0d.state", r),   64'(o_state), 64'(tbl[r].e_state));
      chk($sformatf("rec%0d.locked", r),  64'(o_locked), 64'(tbl[r].e_state == 2));
      chk($sformatf("rec%0d.delay", r),   64'(o_delay), 64'(tbl[r].e_delay));
      chk($sformatf("rec%0d.bits", r),    o_bits, 64'(tbl[r].e_bits));
      if (tbl[r].chk_err != 0)
        chk($sformatf("rec%0d.errors", r), o_errors, 64'(tbl[r].e_err));
      chk($sformatf("rec%0d.fails", r),   64'(o_sweep_fails), 64'(tbl[r].e_fails));
      chk($sformatf("rec%0d.unlocks", r), 64'(o_unlocks), 64'(tbl[r].e_unl));
      $display("rec %0d: state=%0d locked=%0d delay=%0d bits=%0d errors=%0d fails=%0d unlocks=%0d",
               r, o_state, o_locked, o_delay, o_bits, o_errors, o_sweep_fails, o_unlocks);
    end

    // Locked at 11 with bits=1000: clear coincident with a valid sample wins.
    do_sample(11, 1'b0, 1'b1);
    chk("clr_valid.bits",   o_bits, 64'd0);
    chk("clr_valid.errors", o_errors, 64'd0);
    chk("clr_valid.state",  64'(o_state), 64'd2);
    $display("clear+valid: bits=%0d errors=%0d state=%0d", o_bits, o_errors, o_state);

    do_sample(11, 1'b0, 1'b0);
    chk("after_clr.bits", o_bits, 64'd1);
    $display("sample after clear: bits=%0d", o_bits);

    do_idle(1'b0);
    chk("idle.bits", o_bits, 64'd1);
    $display("idle: bits=%0d", o_bits);

    do_sample(11, 1'b1, 1'b0);
    chk("flip.errors", o_errors, 64'd1);
    chk("flip.bits",   o_bits, 64'd2);
    $display("flipped sample: bits=%0d errors=%0d", o_bits, o_errors);

    // Reset in the middle of lock returns everything to zero in one cycle.
    i_reset = 1'b1;
    i_valid = 1'b1;
    @(posedge clock); #1;
    i_reset = 1'b0;
    i_valid = 1'b0;
    chk_all_zero("midreset");
    $display("mid-lock reset: state=%0d locked=%0d bits=%0d", o_state, o_locked, o_bits);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
